// File: rtl/v_hier_pkg.sv
// Shared types and constants for the hierarchy vector driver.
// Vector width, state encoding and expected-response mapping.
package v_hier_pkg;

  localparam int VEC_W = 4;
  localparam logic [VEC_W-1:0] EXP_MASK = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  function automatic logic [VEC_W-1:0] exp_rsp(
    input logic [VEC_W-1:0] v
  );
    return v ^ EXP_MASK;
  endfunction

endpackage

// File: rtl/v_hier_chk.sv
// Compare-and-count: registers the response, counts mismatches
// and timeouts with saturation, keeps a sticky timeout flag.
module v_hier_chk
  import v_hier_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             cap_i,
  input  logic             to_i,
  input  logic             chk_i,
  input  logic [VEC_W-1:0] rsp_i,
  input  logic [VEC_W-1:0] exp_i,
  output logic [7:0]       err_cnt_o,
  output logic             timeout_o
);

  logic [VEC_W-1:0] rsp_q;
  logic             hit_q;
  logic [7:0]       err_q, err_d;
  logic             to_q;
  logic             inc;

  // One increment per vector: either its timeout or its mismatch.
  always_comb begin
    inc   = to_i | (chk_i & hit_q & (rsp_q != exp_i));
    err_d = err_q;
    if (inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Response capture, counters and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q <= '0;
      hit_q <= 1'b0;
      err_q <= '0;
      to_q  <= 1'b0;
    end else if (clr_i) begin
      hit_q <= 1'b0;
      err_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (cap_i) begin
        rsp_q <= rsp_i;
        hit_q <= 1'b1;
      end
      if (to_i) begin
        hit_q <= 1'b0;
      end
      err_q <= err_d;
      to_q  <= to_q | to_i;
    end
  end

  assign err_cnt_o = err_q;
  assign timeout_o = to_q;

endmodule

// File: rtl/v_hier_drv.sv
// Initiator-side vector driver: issues request vectors,
// waits for responses and hands them to the checker.
module v_hier_drv
  import v_hier_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] seed,
  output logic [VEC_W-1:0] avec,
  output logic             avec_vld,
  input  logic [VEC_W-1:0] qvec,
  input  logic             qvec_vld,
  output logic             busy,
  output logic             done,
  output logic [7:0]       err_cnt,
  output logic             timeout
);

  localparam logic [7:0] TO_L = 8'(TIMEOUT);
  localparam logic [8:0] NV_L = 9'(NUM_VEC);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] avec_q, avec_d;
  logic [8:0]       idx_q, idx_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             clr, cap, to_ev, chk;

  // Next-state and control strobes for the run sequencer.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    avec_d  = avec_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    clr     = 1'b0;
    cap     = 1'b0;
    to_ev   = 1'b0;
    chk     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d   = seed;
          idx_d   = '0;
          clr     = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        avec_d  = vec_q;
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (qvec_vld) begin
          cap     = 1'b1;
          state_d = ST_CHECK;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_d == TO_L) begin
            to_ev   = 1'b1;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        chk   = 1'b1;
        vec_d = vec_q + 4'd1;
        idx_d = idx_q + 9'd1;
        if (idx_d == NV_L) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, vector, index and wait counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      avec_q  <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      avec_q  <= avec_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign avec_vld = (state_q == ST_DRIVE);
  assign avec     = avec_vld ? vec_q : avec_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  v_hier_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .cap_i     (cap),
    .to_i      (to_ev),
    .chk_i     (chk),
    .rsp_i     (qvec),
    .exp_i     (exp_rsp(vec_q)),
    .err_cnt_o (err_cnt),
    .timeout_o (timeout)
  );

endmodule

// File: tb/tb_v_hier_drv.sv
// Randomized bench for v_hier_drv with a per-run
// reference model of error count, timeout and run length.
module tb_v_hier_drv;

  localparam int NV = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] seed = 4'h0;
  logic [3:0] avec;
  logic       avec_vld;
  logic [3:0] qvec = 4'h0;
  logic       qvec_vld = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] err_cnt;
  logic       timeout;

  logic       s_start = 1'b0;
  logic [3:0] s_seed = 4'h0;
  logic [3:0] s_avec;
  logic       s_avec_vld;
  logic [3:0] s_qvec = 4'h0;
  logic       s_qvld = 1'b0;
  logic       s_busy;
  logic       s_done;
  logic [7:0] s_err;
  logic       s_to;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;

  bit         sv[int];
  logic [3:0] sq[int];
  int         dly[NV];
  int         mode[NV];
  logic [3:0] rnd[NV];
  bit         late[NV];
  logic [3:0] seen[$];
  int         vidx = 0;

  always #5 clk = ~clk;

  v_hier_drv #(.NUM_VEC(NV), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .avec(avec), .avec_vld(avec_vld),
    .qvec(qvec), .qvec_vld(qvec_vld),
    .busy(busy), .done(done),
    .err_cnt(err_cnt), .timeout(timeout)
  );

  v_hier_drv #(.NUM_VEC(256), .TIMEOUT(TO)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .seed(s_seed),
    .avec(s_avec), .avec_vld(s_avec_vld),
    .qvec(s_qvec), .qvec_vld(s_qvld),
    .busy(s_busy), .done(s_done),
    .err_cnt(s_err), .timeout(s_to)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rsp_of(input logic [3:0] a,
                                        input int i);
    if (mode[i] == 0) return a ^ 4'hF;
    if (mode[i] == 1) return 4'h0;
    return rnd[i];
  endfunction

  // Responder: schedules a response d cycles after each request.
  always @(posedge clk) begin
    int i;
    #1;
    cyc++;
    qvec_vld = sv.exists(cyc) ? sv[cyc] : 1'b0;
    qvec = sq.exists(cyc) ? sq[cyc] : 4'h0;
    sv.delete(cyc);
    sq.delete(cyc);
    if (avec_vld) begin
      seen.push_back(avec);
      i = vidx;
      if (i < NV) begin
        if (dly[i] != 0) begin
          sv[cyc + dly[i]] = 1'b1;
          sq[cyc + dly[i]] = rsp_of(avec, i);
        end else if (late[i]) begin
          sv[cyc + TO + 2] = 1'b1;
          sq[cyc + TO + 2] = avec ^ 4'hF;
        end
      end
      vidx++;
    end
  end

  task automatic plan_good();
    for (int i = 0; i < NV; i++) begin
      dly[i] = 1; mode[i] = 0; rnd[i] = 4'h0; late[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_run(input logic [3:0] sd, input bit poke);
    int e = 0;
    bit t = 0;
    int cy = 0;
    int n0;
    logic [3:0] v;
    logic [3:0] r;
    for (int i = 0; i < NV; i++) begin
      v = sd + 4'(i);
      if (dly[i] == 0) begin
        e++; t = 1'b1; cy += 2 + TO;
      end else begin
        cy += 2 + dly[i];
        if (mode[i] == 0) r = ~v;
        else if (mode[i] == 1) r = 4'h0;
        else r = rnd[i];
        if (r != ~v) e++;
      end
    end
    if (e > 255) e = 255;
    seen.delete();
    vidx = 0;
    tick();
    seed = sd;
    start = 1'b1;
    n0 = cyc;
    tick();
    start = 1'b0;
    check("busy_on", int'(busy), 1);
    check("vld_first", int'(avec_vld), 1);
    check("avec_first", int'(avec), int'(sd));
    for (int k = 0; k < 400 && !done; k++) begin
      if (poke && k == 4) begin
        start = 1'b1;
        seed = ~sd;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("done_seen", int'(done), 1);
    check("done_cyc", cyc - n0, 1 + cy);
    check("err_cnt", int'(err_cnt), e);
    check("timeout", int'(timeout), int'(t));
    check("busy_done", int'(busy), 1);
    check("n_req", seen.size(), NV);
    for (int i = 0; i < seen.size(); i++) begin
      check("avec_seq", int'(seen[i]), int'(4'(sd + 4'(i))));
    end
    check("avec_hold", int'(avec), int'(4'(sd + 4'(NV - 1))));
    tick();
    check("busy_off", int'(busy), 0);
    check("done_pulse", int'(done), 0);
    check("err_hold", int'(err_cnt), e);
  endtask

  initial begin
    int nd;
    plan_good();
    repeat (3) tick();
    check("rst_avec", int'(avec), 0);
    check("rst_vld", int'(avec_vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_to", int'(timeout), 0);
    rst = 1'b0;
    tick();

    do_run(4'h3, 1'b0);
    do_run(4'hE, 1'b0);

    mode[1] = 1;
    do_run(4'h5, 1'b0);

    plan_good();
    dly[1] = 0;
    late[1] = 1'b1;
    dly[2] = TO;
    do_run(4'h9, 1'b0);

    plan_good();
    do_run(4'hA, 1'b1);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NV; i++) begin
        dly[i] = $urandom_range(TO, 0);
        mode[i] = $urandom_range(2, 0);
        rnd[i] = 4'($urandom);
        late[i] = 1'($urandom);
      end
      do_run(4'($urandom), 1'b0);
    end

    plan_good();
    dly[0] = 0;
    seen.delete();
    vidx = 0;
    tick();
    seed = 4'h7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_avec", int'(avec), 0);
    check("mid_vld", int'(avec_vld), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    check("mid_err", int'(err_cnt), 0);
    check("mid_to", int'(timeout), 0);
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done || busy) nd++;
    end
    check("mid_quiet", nd, 0);
    plan_good();
    do_run(4'h7, 1'b0);

    s_seed = 4'h0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int k = 0; k < 4000 && !s_done; k++) tick();
    check("sat_done", int'(s_done), 1);
    check("sat_err", int'(s_err), 255);
    check("sat_to", int'(s_to), 1);
    check("sat_avec", int'(s_avec), 15);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/v_hier_drv.md
# v_hier_drv

Initiator-side vector driver for the hierarchy sub-block interface: sequences 4-bit request vectors onto `avec`, waits for each `qvec` response, checks it against the expected mapping and counts errors and timeouts. Sits beside `v_hier_sub` in the top level, owning the opposite end of the `avec`/`qvec` exchange, and lets a run be launched by a single `start` pulse.

## Interface
- `NUM_VEC`, 16: vectors issued per run (1..256).
- `TIMEOUT`, 8: cycles to wait for `qvec_vld` after a request (1..255).
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch a run; sampled only in IDLE.
- `seed`  in  4  first vector of the run, captured with `start`.
- `avec`  out  4  request vector, valid while `avec_vld`.
- `avec_vld`  out  1  one-cycle request strobe.
- `qvec`  in  4  response vector.
- `qvec_vld`  in  1  response strobe.
- `busy`  out  1  high from accepted `start` until DONE exits.
- `done`  out  1  one-cycle end-of-run pulse.
- `err_cnt`  out  8  mismatches + timeouts this run, saturating at 255.
- `timeout`  out  1  sticky: at least one response timed out this run.

## Operation
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE: `start`=1 -> capture `seed` into vector register, clear index, `err_cnt`, `timeout`; go DRIVE. `start` in any other state ignored.
- DRIVE (1 cycle): `avec_vld`=1, `avec`=vector; clear wait counter; go WAIT.
- WAIT: `qvec_vld`=1 -> register `qvec`, go CHECK. Else wait counter increments; on reaching `TIMEOUT` with no response -> `err_cnt`+1 (saturating), `timeout`=1, go CHECK with compare suppressed.
- CHECK (1 cycle): expected = vector XOR 4'hF; mismatch -> `err_cnt`+1 (saturating). Vector <= vector+1 mod 16 (15 wraps to 0); index+1. Index reaches `NUM_VEC` -> DONE, else DRIVE.
- DONE (1 cycle): `done`=1, `busy` still 1; go IDLE. `err_cnt` and `timeout` hold until next accepted `start`.
- `qvec_vld` outside WAIT ignored (late responses after timeout do not count).
- `qvec_vld` in the same cycle the wait counter reaches `TIMEOUT`: response wins, no timeout recorded.
- `avec` holds last driven value when `avec_vld`=0.

## Timing
- Reset: state IDLE; `avec`=0, `avec_vld`=0, `busy`=0, `done`=0, `err_cnt`=0, `timeout`=0. Reset asserted mid-run aborts immediately with no `done` pulse.
- `start` sampled cycle N -> `avec_vld` cycle N+1, `busy` from N+1.
- Earliest accepted response: cycle after `avec_vld`.
- Per vector minimum: 3 cycles (DRIVE, WAIT with immediate response, CHECK); timeout case: 2+`TIMEOUT` cycles.
- `err_cnt` updates the cycle after CHECK (registered); final value valid in the `done` cycle.
- Run of `NUM_VEC` vectors with immediate responses: `done` at cycle N+1+3*`NUM_VEC`.

## Structure
- Shared package `v_hier_pkg`: `VEC_W`=4, state enum type, `EXP_MASK`=4'hF.
- One sub-module `v_hier_chk`: compare-and-count (registered response, mismatch/timeout increment, 8-bit saturating counter, sticky timeout, clear input). FSM, vector and index counters in `v_hier_drv`.

## Test plan
- `NUM_VEC`=4, `seed`=4'h3, responder returns `avec`^4'hF next cycle -> `avec` 3,4,5,6; `err_cnt`=0, `timeout`=0; `done` at start+13.
- `seed`=4'hE, `NUM_VEC`=4, correct responder -> `avec` E,F,0,1 (wrap), `err_cnt`=0.
- Responder corrupts 2nd response (returns 4'h0) -> `err_cnt`=1 at `done`.
- `TIMEOUT`=8, responder silent on vector 1 -> timeout after 8 WAIT cycles, `timeout`=1, `err_cnt`=1; late `qvec_vld` during next DRIVE ignored; saturation check with `NUM_VEC`=256 all silent -> `err_cnt`=255.
- `start` pulsed while busy -> ignored; `rst` asserted in WAIT -> next cycle all outputs reset values, no `done`; new `start` after reset runs cleanly.
